// File: rtl/spi_reg_target.sv
`timescale 1ns/1ps
// spi_reg_target: SPI mode-0 target, oversampled in the clk domain, one register access per 48-bit frame.
// Define SPI_AUTOINC_EN to stream further 32-bit words at incrementing addresses within one frame.
module spi_reg_target (
    input  logic        clk,
    input  logic        nreset,
    input  logic        spi_clk,
    input  logic        spi_ncs,
    input  logic        spi_din,
    output logic        spi_dout,
    output logic        reg_req,
    output logic        reg_we,
    output logic [11:0] reg_addr,
    output logic [31:0] reg_wdata,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack
);

    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned WIN_W      = 4;
    localparam int unsigned ACK_WINDOW = 8;
    localparam logic [DATA_W-1:0] LATE_VALUE = 32'hDEADDEAD;
    localparam logic [15:0]       SYNC_WORD  = 16'hA5C3;
    localparam logic [1:0]        CMD_RD     = 2'b00;
    localparam logic [1:0]        CMD_WR     = 2'b01;

`ifdef SPI_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    state_t              state, state_nx;
    logic [2:0]          sclk_sync, ncs_sync;
    logic [1:0]          din_sync;
    logic [CNT_W-1:0]    cnt;
    logic [30:0]         rx;
    logic [DATA_W-1:0]   tx;
    logic [1:0]          cmd;
    logic [ADDR_W-1:0]   addr_cur;
    logic [DATA_W-1:0]   rd_word;
    logic [WIN_W-1:0]    win_cnt;
    logic                start_pend;

    logic                sclk_rise, ncs_fall, ncs_high, start, shift_en;
    logic                addr_end, hdr_end, word_first, word_end, wrap, ack_ok;
    logic                rd_issue, wr_issue;
    logic [DATA_W-1:0]   rx_next, rd_next, tx_load;
    logic [ADDR_W-1:0]   rd_addr;

    // Edges are judged between the second synchroniser stage and a third history stage
    assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
    assign ncs_fall   = ~ncs_sync[1] & ncs_sync[2];
    assign ncs_high   = ncs_sync[1];
    assign start      = (state == IDLE) && (start_pend || ncs_fall) && !ncs_high && !reg_req;
    assign shift_en   = sclk_rise && !ncs_high && (state == HDR || state == DATA);
    assign rx_next    = {rx, din_sync[1]};
    assign addr_end   = shift_en && (cnt == CNT_W'(13));
    assign hdr_end    = shift_en && (cnt == CNT_W'(15));
    assign word_first = shift_en && (cnt == CNT_W'(16));
    assign word_end   = shift_en && (cnt == CNT_W'(47));
    assign wrap       = AUTOINC && word_end;
    assign ack_ok     = reg_req && reg_ack && !reg_we && (win_cnt < WIN_W'(ACK_WINDOW));
    assign rd_next    = ack_ok ? reg_rdata : rd_word;
    assign tx_load    = (cmd == CMD_RD) ? rd_next : '0;
    assign rd_issue   = (addr_end && cmd == CMD_RD) || (AUTOINC && word_first && cmd == CMD_RD);
    assign rd_addr    = addr_end ? rx_next[ADDR_W-1:0] : addr_cur + ADDR_W'(1);
    assign wr_issue   = word_end && (cmd == CMD_WR);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start)    state_nx = HDR;
            HDR:     if (hdr_end)  state_nx = DATA;
            DATA:    if (word_end) state_nx = AUTOINC ? DATA : DONE;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (ncs_high) state_nx = IDLE;
    end

    // Pin synchronisers and the serial shift path
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sclk_sync  <= '0;
            ncs_sync   <= '1;
            din_sync   <= '0;
            start_pend <= 1'b0;
            cnt        <= '0;
            rx         <= '0;
            tx         <= '0;
            cmd        <= '0;
            addr_cur   <= '0;
            spi_dout   <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[1:0], spi_clk};
            ncs_sync   <= {ncs_sync[1:0], spi_ncs};
            din_sync   <= {din_sync[0], spi_din};
            start_pend <= !ncs_high && !start && (start_pend || ncs_fall);
            if (ncs_high) begin
                cnt      <= '0;
                spi_dout <= 1'b0;
            end else if (start) begin
                cnt      <= '0;
                tx       <= {SYNC_WORD[14:0], 17'b0};
                spi_dout <= SYNC_WORD[15];
            end else if (shift_en) begin
                rx  <= rx_next[30:0];
                cnt <= wrap ? CNT_W'(16) : cnt + CNT_W'(1);
                if (cnt == CNT_W'(1))  cmd      <= rx_next[1:0];
                if (cnt == CNT_W'(13)) addr_cur <= rx_next[ADDR_W-1:0];
                if (wrap)              addr_cur <= addr_cur + ADDR_W'(1);
                if (hdr_end || wrap) begin
                    spi_dout <= tx_load[31];
                    tx       <= {tx_load[30:0], 1'b0};
                end else if (word_end) begin
                    spi_dout <= 1'b0;
                end else begin
                    spi_dout <= tx[31];
                    tx       <= {tx[30:0], 1'b0};
                end
            end
        end
    end

    // Register bus handshake; a read that misses the ack window returns LATE_VALUE
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            reg_req   <= 1'b0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            rd_word   <= '0;
            win_cnt   <= '0;
        end else begin
            if (reg_req) begin
                if (win_cnt != '1) win_cnt <= win_cnt + WIN_W'(1);
                if (reg_ack) begin
                    reg_req <= 1'b0;
                    if (ack_ok) rd_word <= reg_rdata;
                end
            end else if (rd_issue) begin
                reg_req  <= 1'b1;
                reg_we   <= 1'b0;
                reg_addr <= rd_addr;
                win_cnt  <= '0;
            end else if (wr_issue) begin
                reg_req   <= 1'b1;
                reg_we    <= 1'b1;
                reg_addr  <= addr_cur;
                reg_wdata <= rx_next;
            end
            if (rd_issue) rd_word <= LATE_VALUE;
        end
    end

endmodule

// File: tb/tb_spi_reg_target.sv
`timescale 1ns/1ps
// tb_spi_reg_target: SPI master stimulus with scoreboarded register-bus and frame read-back checks.
module tb_spi_reg_target;

    logic        clk = 1'b0;
    logic        nreset, spi_clk, spi_ncs, spi_din, spi_dout;
    logic        reg_req, reg_we, reg_ack;
    logic [11:0] reg_addr;
    logic [31:0] reg_wdata, reg_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } bus_t;

    typedef struct {
        int           id;
        logic [111:0] val;
        logic [111:0] mask;
    } frm_t;

    bus_t         exp_bus_q[$];
    bus_t         resp_q[$];
    frm_t         exp_frm_q[$];
    logic [111:0] got_frm_q[$];
    int           frame_id = 0;

    always #5 clk = ~clk;

    spi_reg_target dut (
        .clk       (clk),
        .nreset    (nreset),
        .spi_clk   (spi_clk),
        .spi_ncs   (spi_ncs),
        .spi_din   (spi_din),
        .spi_dout  (spi_dout),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack)
    );

    function automatic void chk(input string name, input logic [111:0] got, input logic [111:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endfunction

    task automatic exp_bus(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int delay);
        bus_t b;
        b.we = we; b.addr = addr; b.wdata = wdata; b.rdata = rdata; b.delay = delay;
        exp_bus_q.push_back(b);
        resp_q.push_back(b);
    endtask

    // Expected read plus, when streaming is enabled, the prefetch of the next address
    task automatic exp_read(input logic [11:0] addr, input logic [31:0] rdata, input int delay);
        exp_bus(1'b0, addr, 32'h0, rdata, delay);
`ifdef SPI_AUTOINC_EN
        exp_bus(1'b0, addr + 12'd1, 32'h0, 32'h0, 2);
`endif
    endtask

    task automatic exp_frame(input logic [111:0] val, input logic [111:0] mask);
        frm_t f;
        f.id = frame_id; f.val = val; f.mask = mask;
        exp_frm_q.push_back(f);
    endtask

    function automatic logic [111:0] frame48(input logic [1:0] cmd, input logic [11:0] addr, input logic [31:0] data);
        return {64'h0, cmd, addr, 2'b00, data};
    endfunction

    task automatic spi_xfer(input logic [111:0] data, input int nbits, input bit keep_low);
        logic [111:0] rx;
        rx = '0;
        @(negedge clk);
        spi_ncs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_din = data[i];
            repeat (4) @(negedge clk);
            rx = {rx[110:0], spi_dout};
            spi_clk = 1'b1;
            repeat (4) @(negedge clk);
            spi_clk = 1'b0;
        end
        if (!keep_low) begin
            repeat (4) @(negedge clk);
            spi_ncs = 1'b1;
            got_frm_q.push_back(rx);
            frame_id++;
            repeat (12) @(negedge clk);
        end
    endtask

    // Bus responder: acks each request after the delay queued with it
    initial begin
        bus_t r;
        reg_ack   = 1'b0;
        reg_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (reg_req && nreset) begin
                if (resp_q.size() > 0) begin
                    r = resp_q.pop_front();
                end else begin
                    r.rdata = 32'h0;
                    r.delay = 1;
                end
                repeat (r.delay - 1) @(negedge clk);
                reg_rdata = r.rdata;
                reg_ack   = 1'b1;
                @(negedge clk);
                reg_ack   = 1'b0;
                reg_rdata = 32'h0;
            end
        end
    end

    // Bus monitor: each rising reg_req is compared against the next expected access
    initial begin
        logic prev;
        bus_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reg_req && !prev) begin
                if (exp_bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got we=%b addr=%h, expected no request", reg_we, reg_addr);
                end else begin
                    e = exp_bus_q.pop_front();
                    chk("bus_we", 112'(reg_we), 112'(e.we));
                    chk("bus_addr", 112'(reg_addr), 112'(e.addr));
                    if (e.we) chk("bus_wdata", 112'(reg_wdata), 112'(e.wdata));
                end
            end
            prev = reg_req;
        end
    end

    // Frame monitor: each completed master frame is compared against its expected MISO bits
    initial begin
        logic [111:0] g;
        frm_t         e;
        forever begin
            @(negedge clk);
            while (got_frm_q.size() > 0) begin
                g = got_frm_q.pop_front();
                if (exp_frm_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got %h, expected no frame", g);
                end else begin
                    e = exp_frm_q.pop_front();
                    chk($sformatf("frame%0d_rx", e.id), g & e.mask, e.val & e.mask);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no end of test, expected finish within 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dout"},  112'(spi_dout),  112'(0));
        chk({tag, "_req"},   112'(reg_req),   112'(0));
        chk({tag, "_we"},    112'(reg_we),    112'(0));
        chk({tag, "_addr"},  112'(reg_addr),  112'(0));
        chk({tag, "_wdata"}, 112'(reg_wdata), 112'(0));
    endtask

    localparam logic [111:0] FULL48 = {64'h0, 48'hFFFF_FFFF_FFFF};
    localparam logic [111:0] HDR48  = {64'h0, 16'hFFFF, 32'h0};

    initial begin
        logic [111:0] v, m;
        nreset  = 1'b0;
        spi_clk = 1'b0;
        spi_ncs = 1'b1;
        spi_din = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        nreset = 1'b1;
        repeat (6) @(negedge clk);

        // Write 0x808 = 1; sync word on the header bits
        exp_bus(1'b1, 12'h808, 32'h0000_0001, 32'h0, 2);
        exp_frame({64'h0, 16'hA5C3, 32'h0}, HDR48);
        spi_xfer(frame48(2'b01, 12'h808, 32'h0000_0001), 48, 1'b0);

        // Read 0x014 acked after 3 cycles
        exp_read(12'h014, 32'h005A_5A5A, 3);
        exp_frame({64'h0, 48'hA5C3_005A_5A5A}, FULL48);
        spi_xfer(frame48(2'b00, 12'h014, 32'h0), 48, 1'b0);

        // Read 0x015 acked after 20 cycles -> late value, then a prompt re-read
        exp_read(12'h015, 32'h1111_2222, 20);
        exp_frame({64'h0, 48'hA5C3_DEAD_DEAD}, FULL48);
        spi_xfer(frame48(2'b00, 12'h015, 32'h0), 48, 1'b0);
        exp_read(12'h015, 32'h00CA_CE00, 2);
        exp_frame({64'h0, 48'hA5C3_00CA_CE00}, FULL48);
        spi_xfer(frame48(2'b00, 12'h015, 32'h0), 48, 1'b0);

        // Write abandoned after 30 bits: no access, header still shifted out
        v = 112'hA5C3;
        v = v << 14;
        m = 112'hFFFF;
        m = m << 14;
        exp_frame(v, m);
        spi_xfer(frame48(2'b01, 12'h123, 32'h0000_0055) >> 18, 30, 1'b0);

        // Read 0x7FF after the abort, ack after 1 cycle
        exp_read(12'h7FF, 32'h1234_5678, 1);
        exp_frame({64'h0, 48'hA5C3_1234_5678}, FULL48);
        spi_xfer(frame48(2'b00, 12'h7FF, 32'h0), 48, 1'b0);

        // Ack window edges: 8 cycles is in time, 9 is late
        exp_read(12'h800, 32'hCAFE_F00D, 8);
        exp_frame({64'h0, 48'hA5C3_CAFE_F00D}, FULL48);
        spi_xfer(frame48(2'b00, 12'h800, 32'h0), 48, 1'b0);
        exp_read(12'h800, 32'h0BAD_BEEF, 9);
        exp_frame({64'h0, 48'hA5C3_DEAD_DEAD}, FULL48);
        spi_xfer(frame48(2'b00, 12'h800, 32'h0), 48, 1'b0);

        // Reserved command: no access, zeros in the data phase
        exp_frame({64'h0, 48'hA5C3_0000_0000}, FULL48);
        spi_xfer(frame48(2'b10, 12'h100, 32'hFFFF_FFFF), 48, 1'b0);

        // Reset in the middle of a write frame at bit 20
        spi_xfer(frame48(2'b01, 12'h222, 32'h7777_7777) >> 28, 20, 1'b1);
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("midreset");
        spi_ncs = 1'b1;
        spi_clk = 1'b0;
        repeat (4) @(negedge clk);
        nreset = 1'b1;
        repeat (6) @(negedge clk);

        exp_read(12'h014, 32'h0F0F_0F0F, 4);
        exp_frame({64'h0, 48'hA5C3_0F0F_0F0F}, FULL48);
        spi_xfer(frame48(2'b00, 12'h014, 32'h0), 48, 1'b0);

        exp_bus(1'b1, 12'hFFF, 32'hA5A5_0F0F, 32'h0, 1);
        exp_frame({64'h0, 16'hA5C3, 32'h0}, HDR48);
        spi_xfer(frame48(2'b01, 12'hFFF, 32'hA5A5_0F0F), 48, 1'b0);

`ifdef SPI_AUTOINC_EN
        // Streaming write at 0xFFF wraps to 0x000 and 0x001
        exp_bus(1'b1, 12'hFFF, 32'hAAAA_0001, 32'h0, 2);
        exp_bus(1'b1, 12'h000, 32'hBBBB_0002, 32'h0, 2);
        exp_bus(1'b1, 12'h001, 32'hCCCC_0003, 32'h0, 2);
        v = 112'hA5C3;
        v = v << 96;
        m = 112'hFFFF;
        m = m << 96;
        exp_frame(v, m);
        spi_xfer({2'b01, 12'hFFF, 2'b00, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003}, 112, 1'b0);
`endif

        for (int i = 0; i < 200 && (exp_bus_q.size() > 0 || got_frm_q.size() > 0); i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("bus_queue_drained", 112'(exp_bus_q.size()), 112'(0));
        chk("frame_queue_drained", 112'(exp_frm_q.size()), 112'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
